// File: rtl/branch_bimodal_pht.sv
// rtl/branch_bimodal_pht.sv - bimodal predictor pattern history table with init sweep
// One 2-bit saturating counter per entry; single-entry response buffer with write-first bypass.
module branch_bimodal_pht #(
  parameter  int PHT_size = 2048,
  localparam int IDX_W    = $clog2(PHT_size)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        predict_req_val,
  output logic        predict_req_rdy,
  input  logic [31:0] predict_req_pc,
  output logic        predict_resp_val,
  input  logic        predict_resp_rdy,
  output logic        predict_resp_taken,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        increment_entry,
  input  logic        decrement_entry,
  output logic        entry_upper_reached,
  output logic        entry_lower_reached,
  output logic        init_done
);

  typedef enum logic {INIT, READY} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             resp_val_q, resp_val_d;
  logic             resp_taken_q, resp_taken_d;
  logic [1:0]       pht_q [PHT_size];

  logic             is_ready;
  logic [IDX_W-1:0] req_idx, upd_idx;
  logic [1:0]       upd_cnt, upd_new, req_cnt;
  logic             upd_we, accept;
  logic             unused_pc_bits;

  assign is_ready = (state_q == READY);
  assign req_idx  = predict_req_pc[IDX_W+1:2];
  assign upd_idx  = update_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{predict_req_pc[31:IDX_W+2], predict_req_pc[1:0],
                            update_pc[31:IDX_W+2], update_pc[1:0]};

  assign upd_cnt = pht_q[upd_idx];
  assign upd_we  = is_ready && update_en && (increment_entry ^ decrement_entry);

  always_comb begin
    upd_new = upd_cnt;
    if (increment_entry && !decrement_entry && upd_cnt != 2'd3) begin
      upd_new = upd_cnt + 2'd1;
    end else if (decrement_entry && !increment_entry && upd_cnt != 2'd0) begin
      upd_new = upd_cnt - 2'd1;
    end
  end

  // Same-cycle update to the requested entry is forwarded into the response
  assign req_cnt = (upd_we && upd_idx == req_idx) ? upd_new : pht_q[req_idx];

  assign predict_req_rdy     = is_ready && (!resp_val_q || predict_resp_rdy);
  assign accept              = predict_req_val && predict_req_rdy;
  assign predict_resp_val    = resp_val_q;
  assign predict_resp_taken  = resp_taken_q;
  assign init_done           = is_ready;
  assign entry_upper_reached = is_ready && (upd_cnt == 2'd3);
  assign entry_lower_reached = is_ready && (upd_cnt == 2'd0);

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    resp_val_d   = resp_val_q;
    resp_taken_d = resp_taken_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(PHT_size - 1)) begin
          state_d = READY;
        end
      end
      READY: ;
      default: state_d = INIT;
    endcase
    if (accept) begin
      resp_val_d   = 1'b1;
      resp_taken_d = req_cnt[1];
    end else if (resp_val_q && predict_resp_rdy) begin
      resp_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      resp_val_q   <= 1'b0;
      resp_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      resp_val_q   <= resp_val_d;
      resp_taken_q <= resp_taken_d;
    end
  end

  // Table has no reset of its own; the INIT sweep establishes its contents
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht_q[init_idx_q] <= 2'd1;
    end else if (upd_we) begin
      pht_q[upd_idx] <= upd_new;
    end
  end

endmodule

// File: doc/branch_bimodal_pht.md
# branch_bimodal_pht

Pattern history table (PHT) datapath for the bimodal branch predictor. It holds one 2-bit saturating counter per entry and initialises the table with a sweep after reset. It serves fetch-side prediction requests through a val/rdy request/response pair. It also exposes per-entry saturation status to the bimodal control unit, and applies that unit's increment/decrement commands on update.

## Interface
- PHT_size, 2048, number of counter entries; power of two, ≥ 2; IDX_W = $clog2(PHT_size)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- predict_req_val  in  1  prediction request valid
- predict_req_rdy  out  1  block can accept a prediction request
- predict_req_pc  in  32  PC of the branch to predict
- predict_resp_val  out  1  prediction response valid
- predict_resp_rdy  in  1  consumer accepts the response
- predict_resp_taken  out  1  predicted direction (1 = taken)
- update_en  in  1  resolved-branch update this cycle
- update_pc  in  32  PC of the resolved branch
- increment_entry  in  1  from control: increment the counter at update_pc
- decrement_entry  in  1  from control: decrement the counter at update_pc
- entry_upper_reached  out  1  counter at update_pc == 3
- entry_lower_reached  out  1  counter at update_pc == 0
- init_done  out  1  table sweep complete

## Operation
- Index is pc[IDX_W+1:2] for both request and update PCs. Bits [1:0] and the upper bits are ignored, so aliasing is intended.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction is counter[1].
- FSM has states INIT and READY. Reset asynchronously forces the following:
  - state = INIT, init index = 0
  - predict_resp_val = 0, predict_resp_taken = 0
  - init_done = 0, predict_req_rdy = 0
- INIT:
  - Each clock edge writes 1 (weak-NT) to entry init_idx, then increments init_idx.
  - The edge that writes entry PHT_size-1 moves the FSM to READY. init_idx wraps to 0 there; it is otherwise unused.
  - Updates arriving in INIT are dropped.
  - entry_upper_reached and entry_lower_reached are forced to 0 in INIT.
- READY: init_done = 1. The FSM stays in READY until reset.
- Status outputs are combinational from the current stored counter at update_pc. They are valid in READY regardless of update_en.
- Update write, on the clock edge when READY && update_en:
  - increment_entry alone: counter + 1, saturating at 3.
  - decrement_entry alone: counter − 1, saturating at 0.
  - Both or neither asserted: no change.
  - The 2-bit arithmetic never wraps: 3+1 stays 3, 0−1 stays 0.
- Request handshake:
  - predict_req_rdy = READY && (!predict_resp_val || predict_resp_rdy).
  - A request is accepted on an edge where val && rdy.
- Response buffer (single entry):
  - On an acceptance edge, predict_resp_val is set to 1. predict_resp_taken is set to bit 1 of the entry's next value, which includes any same-cycle update to the same index (write-first bypass).
  - On an edge with resp_val && resp_rdy and no new acceptance, predict_resp_val clears.
  - While resp_val && !resp_rdy, predict_resp_taken holds stable.
- Reset mid-operation discards the pending response and restarts the full INIT sweep.

## Timing
- After reset deasserts, INIT lasts exactly PHT_size edges. init_done and predict_req_rdy rise after edge PHT_size.
- Prediction latency is 1 cycle: the response is valid in the cycle after acceptance.
- Back-to-back throughput is 1 prediction/cycle while predict_resp_rdy = 1.
- An update becomes visible to status outputs and to later predictions in the cycle after its edge.
- Only reset is asynchronous; all other state changes occur on the rising edge of clk.

## Test plan
- Init sweep:
  - Setup: PHT_size = 16; release reset.
  - Required: predict_req_rdy = 0 for 16 cycles, then 1.
  - Then predict PCs 0x00–0x3C (stride 4): all 16 responses are taken = 0; status at any PC shows lower = 0 and upper = 0.
- Saturation:
  - Stimulus: update PC 0x40 with increment ×4.
  - Required: counter reaches 3, upper_reached = 1, prediction taken = 1.
  - Stimulus: decrement ×5.
  - Required: counter reaches 0, lower_reached = 1, taken = 0, no wrap.
- Bypass:
  - Setup: entry at PC 0x8 holds 1.
  - Stimulus: increment update and prediction request for PC 0x8 in the same cycle.
  - Required: response taken = 1.
- Backpressure:
  - Stimulus: hold predict_resp_rdy = 0 after one accepted request.
  - Required: predict_req_rdy = 0, response value stable for 5 cycles.
  - Then raising resp_rdy with req_val held gives back-to-back responses, one per cycle.
- Illegal command: update_en with increment_entry and decrement_entry both 1 on entry value 2 → value stays 2.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously mid-cycle with a response pending and entries trained.
  - Required: predict_resp_val drops immediately.
  - After reset, the sweep reruns and all entries predict not-taken.
